// File: rtl/synapse_event_arbiter.sv
// Packet-level round-robin merge of NG scheduler token streams.
// Ports: iCLK/iRST; iValid_AS/oReady_AS/iData_AS per-group in;
//        oValid_BS/iReady_BS/oData_BS merged out; oBusy status.
module synapse_event_arbiter #(
    parameter int    NG   = 4,
    parameter int    NA   = 4,
    parameter string TYPE = "rc",
    localparam int   SW   = (TYPE == "rc") ? 2 : 1,
    localparam int   AW   = $clog2(NA),
    localparam int   GW   = $clog2(NG),
    localparam int   TW   = 2 + SW + AW,
    localparam int   OW   = 3 + SW + GW + AW
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [NG-1:0]    iValid_AS,
    output logic [NG-1:0]    oReady_AS,
    input  logic [NG*TW-1:0] iData_AS,
    output logic             oValid_BS,
    input  logic             iReady_BS,
    output logic [OW-1:0]    oData_BS,
    output logic             oBusy
);

    typedef enum logic {
        S_IDLE,
        S_LOCK
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_ptr;
    logic [NG-1:0] r_done;
    logic          r_valid;
    logic [OW-1:0] r_data;

    logic [GW-1:0] w_pick;
    logic          w_found;
    logic [NG-1:0] w_elig;
    logic [NG-1:0] w_gsel;
    logic [TW-1:0] w_tok;
    logic          w_ld;
    logic          w_xfer;
    logic          w_end;
    logic          w_glst;

    assign w_ld   = !r_valid || iReady_BS;
    assign w_gsel = {{(NG-1){1'b0}}, 1'b1} << r_grant;
    assign w_tok  = iData_AS[int'(r_grant)*TW +: TW];
    assign w_xfer = (r_state == S_LOCK) && w_ld
                    && iValid_AS[r_grant];
    // Either leap or plst closes the packet.
    assign w_end  = w_xfer && (w_tok[TW-1] || w_tok[TW-2]);
    assign w_glst = w_end && (&(r_done | w_gsel));

    // Ready depends only on state and downstream ready.
    assign oReady_AS = (r_state == S_LOCK && w_ld) ? w_gsel
                                                   : '0;

    // First eligible group at or above r_ptr, wrapping.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_elig  = iValid_AS & ~r_done;
        for (int i = 0; i < NG; i++) begin
            if (!w_found && w_elig[(int'(r_ptr) + i) % NG]) begin
                w_found = 1'b1;
                w_pick  = GW'((int'(r_ptr) + i) % NG);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_LOCK;
            S_LOCK:  if (w_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_done  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_found)
                r_grant <= w_pick;
            if (w_end) begin
                r_ptr  <= (r_grant == GW'(NG-1)) ? '0
                                                 : r_grant + 1'b1;
                r_done <= w_glst ? '0 : (r_done | w_gsel);
            end
            if (w_xfer) begin
                r_valid <= 1'b1;
                r_data  <= {w_tok[TW-1:TW-2], w_glst,
                            w_tok[AW+SW-1:AW], r_grant,
                            w_tok[AW-1:0]};
            end else if (w_ld) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign oValid_BS = r_valid;
    assign oData_BS  = r_data;
    assign oBusy     = (r_state == S_LOCK) || r_valid;

endmodule

// File: tb/tb_synapse_event_arbiter.sv
// Bench for synapse_event_arbiter: directed scenarios plus
// randomized packet rounds against an expected-stream model.
module tb_synapse_event_arbiter;

    localparam int NG = 4;
    localparam int NA = 4;
    localparam int SW = 2;
    localparam int AW = 2;
    localparam int GW = 2;
    localparam int TW = 6;
    localparam int OW = 9;

    logic             iCLK = 1'b0;
    logic             iRST = 1'b1;
    logic [NG-1:0]    iValid_AS = '0;
    logic [NG-1:0]    oReady_AS;
    logic [NG*TW-1:0] iData_AS = '0;
    logic             oValid_BS;
    logic             iReady_BS = 1'b0;
    logic [OW-1:0]    oData_BS;
    logic             oBusy;

    synapse_event_arbiter #(
        .NG(NG), .NA(NA), .TYPE("rc")
    ) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iValid_AS(iValid_AS), .oReady_AS(oReady_AS),
        .iData_AS(iData_AS), .oValid_BS(oValid_BS),
        .iReady_BS(iReady_BS), .oData_BS(oData_BS),
        .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;
    logic [TW-1:0] src_mem [NG][64];
    int            src_hd [NG];
    int            src_tl [NG];
    bit            mid [NG];
    bit            gap_en = 1'b0;
    logic [OW-1:0] got_q[$];
    logic [OW-1:0] exp_q[$];
    int            got_cyc[$];

    function automatic logic [TW-1:0] tok(bit lp, bit pl,
                                          int sub, int ad);
        return {lp, pl, SW'(sub), AW'(ad)};
    endfunction

    function automatic logic [OW-1:0] outt(logic [TW-1:0] t,
                                           int g, bit gl);
        return {t[TW-1], t[TW-2], gl, t[AW+SW-1:AW],
                GW'(g), t[AW-1:0]};
    endfunction

    task automatic push(input int g, input logic [TW-1:0] t);
        src_mem[g][src_tl[g]] = t;
        src_tl[g]++;
    endtask

    task automatic clear_all();
        for (int g = 0; g < NG; g++) begin
            src_hd[g] = 0;
            src_tl[g] = 0;
            mid[g]    = 1'b0;
        end
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
    endtask

    task automatic step(input bit rdy);
        logic [NG-1:0] v;
        logic [TW-1:0] t;
        v = '0;
        @(negedge iCLK);
        iReady_BS = rdy;
        for (int g = 0; g < NG; g++) begin
            if (src_hd[g] < src_tl[g] &&
                !(gap_en && mid[g] && $urandom_range(0, 3) == 0)) begin
                v[g] = 1'b1;
                iData_AS[g*TW +: TW] = src_mem[g][src_hd[g]];
            end else begin
                iData_AS[g*TW +: TW] = TW'($urandom);
            end
        end
        iValid_AS = v;
        #1;
        if (oValid_BS && iReady_BS) begin
            got_q.push_back(oData_BS);
            got_cyc.push_back(cyc);
        end
        for (int g = 0; g < NG; g++) begin
            if (iValid_AS[g] && oReady_AS[g]) begin
                t = src_mem[g][src_hd[g]];
                src_hd[g]++;
                mid[g] = !(t[TW-1] || t[TW-2]);
            end
        end
        cyc++;
    endtask

    task automatic drain(input int n, input int budget,
                         input bit rnd, input string nm);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            step(rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            k++;
        end
        for (int i = 0; i < 4; i++) step(1'b1);
        nvec++;
        if (got_q.size() != n) begin
            nmis++;
            $display("FAIL %s_count got %0d tokens want %0d",
                     nm, got_q.size(), n);
        end
    endtask

    task automatic do_reset();
        @(negedge iCLK);
        iRST      = 1'b1;
        iValid_AS = '0;
        iReady_BS = 1'b0;
        clear_all();
        @(negedge iCLK);
        iRST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec += 5;
        if (oValid_BS !== 1'b0) begin
            nmis++;
            $display("FAIL rst_valid got %b want 0", oValid_BS);
        end
        if (oData_BS !== '0) begin
            nmis++;
            $display("FAIL rst_data got %h want 0", oData_BS);
        end
        if (oReady_AS !== '0) begin
            nmis++;
            $display("FAIL rst_ready got %b want 0", oReady_AS);
        end
        if (oBusy !== 1'b0) begin
            nmis++;
            $display("FAIL rst_busy got %b want 0", oBusy);
        end
        if (dut.r_done !== '0) begin
            nmis++;
            $display("FAIL rst_done got %b want 0", dut.r_done);
        end
    endtask

    task automatic test_round();
        clear_all();
        for (int g = 0; g < NG; g++) begin
            push(g, tok(0, 1, 0, g));
            exp_q.push_back(outt(tok(0, 1, 0, g), g, g == NG-1));
        end
        drain(NG, 40, 1'b0, "round");
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++;
            if (got_q[i] !== exp_q[i]) begin
                nmis++;
                $display("FAIL round_tok%0d got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < got_cyc.size(); i++) begin
            nvec++;
            if (got_cyc[i] - got_cyc[i-1] != 2) begin
                nmis++;
                $display("FAIL round_gap%0d got %0d want 2",
                         i, got_cyc[i] - got_cyc[i-1]);
            end
        end
    endtask

    task automatic test_packet();
        clear_all();
        push(2, tok(0, 0, 0, 0));
        push(2, tok(0, 0, 2, 1));
        push(2, tok(0, 1, 3, 3));
        step(1'b1);
        push(0, tok(0, 1, 1, 2));
        exp_q.push_back(outt(tok(0, 0, 0, 0), 2, 0));
        exp_q.push_back(outt(tok(0, 0, 2, 1), 2, 0));
        exp_q.push_back(outt(tok(0, 1, 3, 3), 2, 0));
        exp_q.push_back(outt(tok(0, 1, 1, 2), 0, 0));
        drain(4, 40, 1'b0, "pkt");
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++;
            if (got_q[i] !== exp_q[i]) begin
                nmis++;
                $display("FAIL pkt_tok%0d got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_leap();
        clear_all();
        push(1, tok(1, 0, 2, 1));
        exp_q.push_back(outt(tok(1, 0, 2, 1), 1, 0));
        drain(1, 20, 1'b0, "leap");
        nvec += 2;
        if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin
            nmis++;
            $display("FAIL leap_tok got %h want %h",
                     got_q[0], exp_q[0]);
        end
        if (dut.r_done !== 4'b0111) begin
            nmis++;
            $display("FAIL leap_done got %b want 0111", dut.r_done);
        end
    endtask

    task automatic test_rr();
        do_reset();
        for (int g = 1; g < NG; g++) begin
            push(g, tok(0, 1, 0, g));
            exp_q.push_back(outt(tok(0, 1, 0, g), g, 0));
        end
        drain(3, 40, 1'b0, "rr_a");
        push(0, tok(0, 1, 2, 0));
        exp_q.push_back(outt(tok(0, 1, 2, 0), 0, 1));
        drain(4, 20, 1'b0, "rr_b");
        push(0, tok(0, 1, 1, 0));
        push(3, tok(0, 1, 1, 3));
        exp_q.push_back(outt(tok(0, 1, 1, 3), 3, 0));
        exp_q.push_back(outt(tok(0, 1, 1, 0), 0, 0));
        drain(6, 30, 1'b0, "rr_c");
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++;
            if (got_q[i] !== exp_q[i]) begin
                nmis++;
                $display("FAIL rr_tok%0d got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_lockstep();
        do_reset();
        push(0, tok(0, 1, 0, 1));
        push(0, tok(0, 1, 0, 2));
        for (int i = 0; i < 12; i++) step(1'b1);
        nvec += 3;
        if (got_q.size() != 1) begin
            nmis++;
            $display("FAIL lock_early got %0d tokens want 1",
                     got_q.size());
        end
        if (dut.r_done !== 4'b0001) begin
            nmis++;
            $display("FAIL lock_done got %b want 0001", dut.r_done);
        end
        if (oBusy !== 1'b0) begin
            nmis++;
            $display("FAIL lock_busy got %b want 0", oBusy);
        end
        exp_q.push_back(outt(tok(0, 1, 0, 1), 0, 0));
        for (int g = 1; g < NG; g++) begin
            push(g, tok(0, 1, 3, g));
            exp_q.push_back(outt(tok(0, 1, 3, g), g, g == NG-1));
        end
        exp_q.push_back(outt(tok(0, 1, 0, 2), 0, 0));
        drain(5, 40, 1'b0, "lock");
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++;
            if (got_q[i] !== exp_q[i]) begin
                nmis++;
                $display("FAIL lock_tok%0d got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [OW-1:0] held;
        do_reset();
        push(0, tok(0, 0, 1, 0));
        push(0, tok(0, 0, 2, 1));
        push(0, tok(0, 1, 3, 2));
        exp_q.push_back(outt(tok(0, 0, 1, 0), 0, 0));
        exp_q.push_back(outt(tok(0, 0, 2, 1), 0, 0));
        exp_q.push_back(outt(tok(0, 1, 3, 2), 0, 0));
        held = exp_q[0];
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            nvec += 3;
            if (oValid_BS !== 1'b1) begin
                nmis++;
                $display("FAIL stall_valid%0d got %b want 1",
                         i, oValid_BS);
            end
            if (oData_BS !== held) begin
                nmis++;
                $display("FAIL stall_data%0d got %h want %h",
                         i, oData_BS, held);
            end
            if (oReady_AS !== '0) begin
                nmis++;
                $display("FAIL stall_ready%0d got %b want 0",
                         i, oReady_AS);
            end
        end
        drain(3, 30, 1'b0, "stall");
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++;
            if (got_q[i] !== exp_q[i]) begin
                nmis++;
                $display("FAIL stall_tok%0d got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        for (int i = 0; i < 3; i++) push(2, tok(0, 0, 0, i));
        push(2, tok(0, 1, 0, 3));
        step(1'b1);
        step(1'b1);
        step(1'b1);
        @(negedge iCLK);
        iRST = 1'b1;
        @(negedge iCLK);
        nvec += 4;
        if (oValid_BS !== 1'b0) begin
            nmis++;
            $display("FAIL midrst_valid got %b want 0", oValid_BS);
        end
        if (dut.r_done !== '0) begin
            nmis++;
            $display("FAIL midrst_done got %b want 0", dut.r_done);
        end
        if (oBusy !== 1'b0) begin
            nmis++;
            $display("FAIL midrst_busy got %b want 0", oBusy);
        end
        if (oReady_AS !== '0) begin
            nmis++;
            $display("FAIL midrst_ready got %b want 0", oReady_AS);
        end
        iRST      = 1'b0;
        iValid_AS = '0;
        clear_all();
    endtask

    task automatic test_random();
        int len;
        logic [TW-1:0] t;
        do_reset();
        gap_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int g = 0; g < NG; g++) begin
                if ($urandom_range(0, 4) == 0) begin
                    t = tok(1, $urandom_range(0, 1),
                            $urandom_range(0, 3),
                            $urandom_range(0, NA-1));
                    push(g, t);
                    exp_q.push_back(outt(t, g, g == NG-1));
                end else begin
                    len = $urandom_range(1, 4);
                    for (int k = 0; k < len; k++) begin
                        t = tok(0, k == len-1,
                                $urandom_range(0, 3),
                                $urandom_range(0, NA-1));
                        push(g, t);
                        exp_q.push_back(outt(t, g,
                            g == NG-1 && k == len-1));
                    end
                end
            end
        end
        drain(exp_q.size(), 3000, 1'b1, "rand");
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            nvec++;
            if (got_q[i] !== exp_q[i]) begin
                nmis++;
                $display("FAIL rand_tok%0d got %h want %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        gap_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round();
        test_packet();
        test_leap();
        test_rr();
        test_lockstep();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nmis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/synapse_event_arbiter.md
Name: synapse_event_arbiter

Overview:
- Merges the spike-event token streams of NG synapse-scheduler cores, each serving one group of NA neurons, into one stream for a shared synaptic accumulator.
- Arbitrates at packet granularity. A packet is the token run one core emits per network update: address tokens ending in a last-flagged token, or a single leap token.
- Enforces one packet per group per round and round-robin order between groups.
- Extends each address with the group index and flags the final token of each round.

Parameters:
- NG, 4, number of scheduler cores (groups); at least 2.
- NA, 4, neurons per group (address range per core).
- TYPE, "rc", "rc" gives a 2-bit sub field; "cbm" gives a 1-bit sub field.
- SW, derived, (TYPE=="rc") ? 2 : 1.
- TW, derived, 2+SW+$clog2(NA), input token width. Token layout, MSB first: {leap, plst, sub[SW], addr[$clog2(NA)]}.
- OW, derived, 3+SW+$clog2(NG)+$clog2(NA), output token width.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  synchronous active-high reset.
- iValid_AS  in  NG  per-group token valid.
- oReady_AS  out  NG  per-group token ready.
- iData_AS  in  NG*TW  group g token at bits [g*TW +: TW].
- oValid_BS  out  1  merged token valid (registered).
- iReady_BS  in  1  downstream ready.
- oData_BS  out  OW  merged token {leap, plst, glst, sub, grp[$clog2(NG)], addr} (registered).
- oBusy  out  1  high in LOCK state or while oValid_BS is high.

Behaviour:
- Reset is iRST, synchronous, active-high; clock is iCLK.
- Reset values: oValid_BS=0, oData_BS=0, oReady_AS=0, state=IDLE, rgrant=0, rptr=0, rdone=0.
- A reset mid-packet or mid-round discards any held output token and all round progress.
- Output register stage:
  - ld = !oValid_BS || iReady_BS.
  - Input transfer on group g: iValid_AS[g] && oReady_AS[g].
  - On a transfer, the output register loads the token next edge with grp=g and glst computed as below.
  - If ld is high with no transfer, oValid_BS goes to 0.
  - Latency is 1 cycle; throughput is 1 token/cycle within a packet.
- Combinational paths:
  - oReady_AS has no combinational path from any iValid_AS or iData_AS.
  - oReady_AS may depend combinationally on iReady_BS.
  - oValid_BS and oData_BS are purely registered.
- State IDLE:
  - oReady_AS=0.
  - Eligible set elig = iValid_AS & ~rdone.
  - If elig is nonzero: rgrant <= first set bit of elig, searching upward from rptr with wrap modulo NG; next state is LOCK.
  - If elig is zero, stay in IDLE.
- State LOCK:
  - oReady_AS[rgrant] = ld; all other bits are 0.
  - A packet ends on a transfer whose token has leap=1 or plst=1. On packet end:
    - rdone[rgrant] <= 1.
    - rptr <= (rgrant+1) mod NG.
    - Next state is IDLE.
  - glst = packet end && ((rdone | onehot(rgrant)) == all ones).
  - When glst is set, rdone <= 0 instead, and the next round starts on the following cycle.
- Each packet costs one IDLE bubble cycle.
- Groups already served this round are ignored even if valid. A group with no pending data therefore stalls round completion; this is intended lockstep behaviour.
- leap, plst, sub and addr pass through unchanged.
- Downstream stall: tokens are held and oData_BS is stable while oValid_BS && !iReady_BS. No token is dropped or duplicated.
- Simultaneous output drain and new load in the same cycle is supported (ld=1 via iReady_BS).

Test Plan:
- Reset, then all four groups present 1-token packets {leap=0, plst=1, addr=g}. Required: outputs in grp order 0,1,2,3; glst=1 only on grp 3; each token 2 cycles after the previous one.
- Group 2 sends a 3-token packet (addr 0, 1, 3 with plst on addr 3) while group 0 is also valid. Required: all 3 tokens from grp 2 are contiguous and are not interleaved with grp 0.
- Group 1 sends a leap token {leap=1}. Required: the output shows leap=1, grp=1, ends the packet, and rdone[1] is set.
- After round completion with rptr=1, groups 0 and 3 are both valid. Required: grp 3 is granted first, then grp 0.
- Group 0 is still valid after being served while groups 1–3 are idle. Required: no grant to group 0 until the round completes (glst=1 observed).
- Hold iReady_BS=0 for 5 cycles mid-packet. Required: oData_BS is stable, oReady_AS=0, and no token is lost. Assert iRST mid-packet: oValid_BS=0 and rdone=0 the next cycle.
